// File: rtl/mux_arb_pkg.sv
// Shared types for the two-requester round-robin arbiter.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  typedef logic req_idx_t;

endpackage

// File: rtl/mux_arbiter_mux.sv
// Team 2:1 datapath mux, widened by parameter; s = 1 selects d1.
module mux #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin burst arbiter sharing one registered output stage between two
// valid/ready requesters; drives the select of the shared 2:1 data mux.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output req_idx_t         out_src,
  input  logic             out_ready,
  output logic             sel,
  output state_t           state
);

  // Handshake: a beat moves when valid && ready on the same rising edge;
  // ready never depends on the same requester's valid.

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(MAX_BURST - 1);

  state_t           state_next;
  logic             prio, prio_next;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_next;
  logic [WIDTH-1:0] mux_data;
  logic             slot_free;
  logic             xfer;
  logic             xfer_last;
  req_idx_t         src;

  mux #(.WIDTH(WIDTH)) u_mux (
    .d0(req0_data),
    .d1(req1_data),
    .s (sel),
    .y (mux_data)
  );

  // Output stage can take a beat if empty or being drained this cycle.
  assign slot_free = !out_valid || out_ready;

  always_comb begin
    state_next    = state;
    prio_next     = prio;
    beat_cnt_next = beat_cnt;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    xfer          = 1'b0;
    xfer_last     = 1'b0;
    src           = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0_valid && req1_valid) state_next = prio ? GRANT1 : GRANT0;
        else if (req0_valid)          state_next = GRANT0;
        else if (req1_valid)          state_next = GRANT1;
      end
      GRANT0: begin
        req0_ready = slot_free;
        xfer       = req0_valid && slot_free;
        xfer_last  = req0_last || (beat_cnt == CNT_CAP);
        src        = 1'b0;
      end
      GRANT1: begin
        req1_ready = slot_free;
        xfer       = req1_valid && slot_free;
        xfer_last  = req1_last || (beat_cnt == CNT_CAP);
        src        = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    if (xfer) begin
      if (xfer_last) begin
        state_next    = IDLE;
        prio_next     = !src;
        beat_cnt_next = '0;
      end else begin
        beat_cnt_next = beat_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      prio     <= 1'b0;
      beat_cnt <= '0;
      sel      <= 1'b0;
    end else begin
      state    <= state_next;
      prio     <= prio_next;
      beat_cnt <= beat_cnt_next;
      sel      <= (state_next == GRANT1);
    end
  end

  // Output register holds its beat while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_last  <= xfer_last;
      out_src   <= src;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model and beat scoreboard.
module tb_mux_arbiter;
  import mux_arb_pkg::*;

  localparam int WIDTH     = 4;
  localparam int MAX_BURST = 4;

  logic             clk, rst;
  logic             req0_valid, req0_last, req0_ready;
  logic [WIDTH-1:0] req0_data;
  logic             req1_valid, req1_last, req1_ready;
  logic [WIDTH-1:0] req1_data;
  logic             out_valid, out_last, out_ready, sel;
  logic [WIDTH-1:0] out_data;
  req_idx_t         out_src;
  state_t           state;

  mux_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_src(out_src),
    .out_ready(out_ready), .sel(sel), .state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model: grant owner (-1 = none), preference, beats in grant, output stage
  int               owner;
  bit               prio_m;
  int               cnt_m;
  bit               ov_m, ol_m, os_m;
  logic [WIDTH-1:0] od_m;

  // scoreboard: beats accepted from each requester, awaiting consumption
  logic [WIDTH-1:0] exp_q0[$];
  logic [WIDTH-1:0] exp_q1[$];

  // directed stimulus queues and per-run records
  logic [WIDTH-1:0] q0d[$], q1d[$];
  bit               q0l[$], q1l[$];
  bit               rec_src[$], rec_last[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic state_t exp_state(input int o);
    if (o < 0) return IDLE;
    return (o == 0) ? GRANT0 : GRANT1;
  endfunction

  task automatic model_reset();
    owner  = -1;
    prio_m = 1'b0;
    cnt_m  = 0;
    ov_m   = 1'b0;
    ol_m   = 1'b0;
    os_m   = 1'b0;
    od_m   = '0;
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // one clock cycle: drive at negedge, check readys, then check registered outputs
  task automatic cycle(input bit v0, input logic [WIDTH-1:0] d0, input bit l0,
                       input bit v1, input logic [WIDTH-1:0] d1, input bit l1,
                       input bit ordy, output bit acc0, output bit acc1);
    bit               e0, e1, x, lst;
    logic [WIDTH-1:0] exp_d;
    @(negedge clk);
    req0_valid = v0; req0_data = d0; req0_last = l0;
    req1_valid = v1; req1_data = d1; req1_last = l1;
    out_ready  = ordy;
    #1;
    e0 = (owner == 0) && (!ov_m || ordy);
    e1 = (owner == 1) && (!ov_m || ordy);
    check("req0_ready", req0_ready, e0);
    check("req1_ready", req1_ready, e1);
    check("sel", sel, owner == 1);
    acc0 = v0 && e0;
    acc1 = v1 && e1;
    if (ov_m && ordy) begin
      check("out_valid_consume", out_valid, 1);
      if ((os_m ? exp_q1.size() : exp_q0.size()) == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        exp_d = os_m ? exp_q1.pop_front() : exp_q0.pop_front();
        check("sb_data", out_data, exp_d);
      end
    end
    @(posedge clk);
    #1;
    if (acc0 || acc1) begin
      x   = acc1;
      lst = x ? l1 : l0;
      if (x) exp_q1.push_back(d1); else exp_q0.push_back(d0);
      ov_m = 1'b1;
      od_m = x ? d1 : d0;
      os_m = x;
      ol_m = lst || (cnt_m == MAX_BURST - 1);
      if (ol_m) begin
        owner  = -1;
        prio_m = !x;
        cnt_m  = 0;
      end else begin
        cnt_m++;
      end
    end else begin
      if (ordy) ov_m = 1'b0;
      if (owner < 0) begin
        if (v0 && v1)  owner = prio_m ? 1 : 0;
        else if (v0)   owner = 0;
        else if (v1)   owner = 1;
      end
    end
    check("out_valid", out_valid, ov_m);
    if (ov_m) begin
      check("out_data", out_data, od_m);
      check("out_src", out_src, os_m);
      check("out_last", out_last, ol_m);
    end
    check("state", state, exp_state(owner));
  endtask

  // driver: present queue heads until all accepted (or stop_after beats), stall window on out_ready
  task automatic run_queues(input int max_cyc, input int stall_s, input int stall_len,
                            input int stop_after, output int cycles);
    bit a0, a1, ordy;
    cycles = 0;
    rec_src.delete();
    rec_last.delete();
    while ((q0d.size() + q1d.size()) != 0 && cycles < max_cyc && rec_src.size() != stop_after) begin
      ordy = !(cycles >= stall_s && cycles < stall_s + stall_len);
      cycle(q0d.size() != 0, (q0d.size() != 0) ? q0d[0] : '0, (q0l.size() != 0) ? q0l[0] : 1'b0,
            q1d.size() != 0, (q1d.size() != 0) ? q1d[0] : '0, (q1l.size() != 0) ? q1l[0] : 1'b0,
            ordy, a0, a1);
      if (a0) begin void'(q0d.pop_front()); void'(q0l.pop_front()); rec_src.push_back(1'b0); rec_last.push_back(out_last); end
      if (a1) begin void'(q1d.pop_front()); void'(q1l.pop_front()); rec_src.push_back(1'b1); rec_last.push_back(out_last); end
      cycles++;
    end
    check("run_complete", ((q0d.size() + q1d.size()) == 0) || (rec_src.size() == stop_after), 1);
    if (stop_after < 0) begin
      for (int i = 0; i < 2; i++) cycle(0, '0, 0, 0, '0, 0, 1, a0, a1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_src", out_src, 0);
    check("rst_sel", sel, 0);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_state", state, IDLE);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    q0d.delete(); q0l.delete(); q1d.delete(); q1l.delete();
  endtask

  initial begin
    int               cyc;
    bit               prio_start, a0, a1, h0, h1, hl0, hl1, ordy;
    logic [WIDTH-1:0] hd0, hd1;

    // reset with both requesters asking
    rst = 1'b1;
    req0_valid = 1'b1; req0_data = 4'h5; req0_last = 1'b1;
    req1_valid = 1'b1; req1_data = 4'h6; req1_last = 1'b1;
    out_ready  = 1'b1;
    model_reset();
    #2;
    check("init_out_valid", out_valid, 0);
    check("init_out_data", out_data, 0);
    check("init_out_last", out_last, 0);
    check("init_out_src", out_src, 0);
    check("init_sel", sel, 0);
    check("init_req0_ready", req0_ready, 0);
    check("init_req1_ready", req1_ready, 0);
    check("init_state", state, IDLE);
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;
    owner = 0;
    check("first_grant", state, GRANT0);
    check("first_ready0", req0_ready, 1);
    check("first_ready1", req1_ready, 0);

    // close req0's grant with one last beat
    q0d.push_back(4'h5); q0l.push_back(1'b1);
    run_queues(10, 99, 0, -1, cyc);

    // single requester: A, B, C on req1
    q1d = '{4'hA, 4'hB, 4'hC}; q1l = '{1'b0, 1'b0, 1'b1};
    run_queues(20, 99, 0, -1, cyc);
    check("single_count", rec_src.size(), 3);
    check("single_src", rec_src[0] & rec_src[1] & rec_src[2], 1);
    check("single_last_ab", rec_last[0] | rec_last[1], 0);
    check("single_last_c", rec_last[2], 1);
    check("single_idle", state, IDLE);

    // contention: 2-beat bursts on both requesters
    prio_start = prio_m;
    for (int i = 0; i < 4; i++) begin
      q0d.push_back(4'($urandom_range(0, 15))); q0l.push_back(i[0]);
      q1d.push_back(4'($urandom_range(0, 15))); q1l.push_back(i[0]);
    end
    run_queues(40, 99, 0, 8, cyc);
    check("contend_cycles", cyc, 12);
    for (int i = 0; i < 8; i++) check("contend_order", rec_src[i], ((i / 2) % 2) ^ int'(prio_start));
    for (int i = 0; i < 2; i++) cycle(0, '0, 0, 0, '0, 0, 1, a0, a1);

    // burst cap: req0 6 beats (last only on 6th), req1 waiting with one beat
    for (int i = 0; i < 6; i++) begin q0d.push_back(4'(i + 1)); q0l.push_back(i == 5); end
    q1d.push_back(4'hE); q1l.push_back(1'b1);
    run_queues(40, 99, 0, -1, cyc);
    check("cap_count", rec_src.size(), 7);
    for (int i = 0; i < 7; i++) check("cap_order", rec_src[i], i == 4);
    check("cap_last3", rec_last[3], 1);
    check("cap_last2", rec_last[2], 0);
    check("cap_last4", rec_last[4], 1);
    check("cap_last6", rec_last[6], 1);

    // backpressure: out_ready low 3 cycles mid-burst
    for (int i = 0; i < 4; i++) begin q0d.push_back(4'(8 + i)); q0l.push_back(i == 3); end
    run_queues(40, 3, 3, -1, cyc);
    check("bp_count", rec_src.size(), 4);
    check("bp_src", rec_src[0] | rec_src[1] | rec_src[2] | rec_src[3], 0);
    check("bp_drained", exp_q0.size() + exp_q1.size(), 0);

    // reset after beat 2 of 4, then a fresh burst
    for (int i = 0; i < 4; i++) begin q0d.push_back(4'(3 + i)); q0l.push_back(i == 3); end
    run_queues(40, 99, 0, 2, cyc);
    check("mid_count", rec_src.size(), 2);
    do_reset();
    for (int i = 0; i < 3; i++) begin q1d.push_back(4'(12 + i)); q1l.push_back(i == 2); end
    run_queues(20, 99, 0, -1, cyc);
    check("fresh_count", rec_src.size(), 3);
    check("fresh_last", rec_last[2], 1);
    check("fresh_not_last", rec_last[1], 0);

    // randomized traffic
    h0 = 0; h1 = 0; hd0 = '0; hd1 = '0; hl0 = 0; hl1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!h0 && $urandom_range(0, 3) != 0) begin
        h0 = 1; hd0 = 4'($urandom_range(0, 15)); hl0 = ($urandom_range(0, 3) == 0);
      end
      if (!h1 && $urandom_range(0, 3) != 0) begin
        h1 = 1; hd1 = 4'($urandom_range(0, 15)); hl1 = ($urandom_range(0, 3) == 0);
      end
      ordy = ($urandom_range(0, 3) != 0);
      cycle(h0, hd0, hl0, h1, hd1, hl1, ordy, a0, a1);
      if (a0) h0 = 0;
      if (a1) h1 = 0;
    end
    for (int i = 0; i < 3; i++) cycle(0, '0, 0, 0, '0, 0, 1, a0, a1);
    check("sb_empty", exp_q0.size() + exp_q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
